seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed scan controller that drives the inputs of the 4-digit seven-segment decoder.
- Holds a 16-bit hex value and 4 decimal-point flags, and cycles digit select 0→1→2→3 at a programmable refresh rate.
- Presents the matching nibble and dot for the selected digit, plus a blank flag for leading-zero suppression.
- New values are accepted through a load strobe and applied only at frame boundaries, so a frame is never displayed half-updated.

Parameters:
REFRESH_DIV, 100000, clock cycles each digit is held (≥2); 100000 at 100 MHz gives 1 kHz per digit.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET  input  1  synchronous reset, active-low
ENABLE_IN  input  1  1 = scanning runs; 0 = scan frozen and display blanked
LOAD_IN  input  1  one-cycle strobe; captures VALUE_IN and DOTS_IN into the staging register
VALUE_IN  input  16  hex value; digit k = VALUE_IN[4k+3:4k]
DOTS_IN  input  4  decimal point per digit, bit k = digit k, 1 = lit
BLANK_LZ_IN  input  1  1 = suppress leading zeros
PENDING_OUT  output  1  staged value not yet applied to the display
SEG_SELECT_OUT  output  2  current digit index, goes to decoder SEG_SELECT_IN
BIN_OUT  output  4  nibble of the current digit, goes to decoder BIN_IN
DOT_OUT  output  1  dot of the current digit, active-high, goes to decoder DOT_IN
BLANK_OUT  output  1  1 = top level must force the anode of the current digit off
FRAME_OUT  output  1  one-cycle pulse on the first cycle of each new frame (digit 0)

Behaviour:
- Reset (RESET=0 at clock edge) clears the following; all outputs read 0 in the cycle after reset:
  - prescaler and digit counter
  - staging value, staging dots and PENDING_OUT
  - display value and display dots
  - FRAME_OUT
- Prescaler:
  - Counts 0..REFRESH_DIV-1 while ENABLE_IN=1, then wraps to 0.
  - Tick = prescaler at REFRESH_DIV-1 with ENABLE_IN=1.
  - On a tick the digit counter increments, wrapping 3→0.
  - Each digit is therefore held exactly REFRESH_DIV cycles; a full frame is 4×REFRESH_DIV cycles.
- Frame boundary: a tick while the digit counter is 3.
  - If PENDING_OUT=1: display value and dots take the staging registers and PENDING_OUT clears, on the same edge that the digit counter goes to 0.
  - FRAME_OUT is high for the first cycle in which SEG_SELECT_OUT=0.
- Load:
  - LOAD_IN=1 writes VALUE_IN/DOTS_IN into staging and sets PENDING_OUT.
  - Latest load wins; a load while pending overwrites staging.
  - LOAD_IN together with a frame boundary: the display takes the OLD staging contents, staging takes the new inputs, and PENDING_OUT stays 1.
- Output timing:
  - SEG_SELECT_OUT equals the digit counter.
  - BIN_OUT and DOT_OUT are selected from the display registers by the digit counter.
  - All outputs are registered or direct register functions and are stable for the whole digit period.
- Leading-zero blanking: with BLANK_LZ_IN=1, digit k (k=1..3) is blanked when both hold:
  - display nibbles k..3 are all zero;
  - display dots k..3 are all zero.
  - Digit 0 is never blanked by this rule. With BLANK_LZ_IN=0, BLANK_OUT=0 except when ENABLE_IN=0.
- ENABLE_IN=0:
  - Prescaler and digit counter hold their values and no ticks occur.
  - BLANK_OUT=1 and FRAME_OUT=0.
  - Loads are still accepted but are not applied until scanning resumes and a frame boundary occurs.
  - On re-enable, scanning resumes from the held count.
- RESET asserted mid-frame or mid-pending: everything returns to reset values and the staged value is discarded.

Test Plan:
All scenarios use REFRESH_DIV=4.
- Reset then ENABLE_IN=1, no load → SEG_SELECT_OUT steps 0,1,2,3,0, each held exactly 4 cycles; BIN_OUT=0; FRAME_OUT pulses every 16 cycles.
- LOAD_IN with VALUE_IN=16'h12AF, DOTS_IN=4'b0100 during digit 1 → PENDING_OUT=1 until the next 3→0 transition. The following frame shows BIN_OUT=F,A,2,1 for digits 0..3, with DOT_OUT=1 only on digit 2.
- Two loads in one frame (16'h1111, then 16'h2222) → the next frame shows 2,2,2,2 and 1111 is never displayed.
- LOAD_IN of 16'h3333 on the same cycle as the frame-boundary tick while 16'h1111 is pending → the new frame shows 1111, PENDING_OUT stays 1, and the frame after shows 3333.
- BLANK_LZ_IN=1, value 16'h0050, DOTS=0 → BLANK_OUT=1 on digits 3 and 2, 0 on digits 1 and 0. With value 16'h0000, BLANK_OUT=1 on digits 3,2,1 and digit 0 shows 0.
- ENABLE_IN=0 for 10 cycles mid-digit 2 → SEG_SELECT_OUT stays 2 and BLANK_OUT=1. After re-enable the remaining digit-2 cycles complete. RESET=0 during pending → PENDING_OUT=0 and the display shows 0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit seven-segment scan controller: cycles the digit select at a fixed
// refresh rate and swaps in newly loaded values only on frame boundaries.
module seg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE_IN,
  input  logic        LOAD_IN,
  input  logic [15:0] VALUE_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        BLANK_LZ_IN,
  output logic        PENDING_OUT,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        BLANK_OUT,
  output logic        FRAME_OUT
);

  localparam int            PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    digit_q, digit_d;
  logic [15:0]   stage_val_q, stage_val_d;
  logic [3:0]    stage_dots_q, stage_dots_d;
  logic          pending_q, pending_d;
  logic [15:0]   disp_val_q, disp_val_d;
  logic [3:0]    disp_dots_q, disp_dots_d;
  logic          frame_q, frame_d;

  logic tick;
  logic boundary;

  assign tick     = ENABLE_IN && (presc_q == PRESC_MAX);
  assign boundary = tick && (digit_q == 2'd3);

  always_comb begin
    presc_d      = presc_q;
    digit_d      = digit_q;
    stage_val_d  = stage_val_q;
    stage_dots_d = stage_dots_q;
    pending_d    = pending_q;
    disp_val_d   = disp_val_q;
    disp_dots_d  = disp_dots_q;
    frame_d      = boundary;

    if (ENABLE_IN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      digit_d = digit_q + 2'd1;
    end

    // The display always takes the pre-existing staging contents, so a load
    // coinciding with the boundary stays pending for the following frame.
    if (boundary && pending_q) begin
      disp_val_d  = stage_val_q;
      disp_dots_d = stage_dots_q;
      pending_d   = 1'b0;
    end
    if (LOAD_IN) begin
      stage_val_d  = VALUE_IN;
      stage_dots_d = DOTS_IN;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      presc_q      <= '0;
      digit_q      <= 2'd0;
      stage_val_q  <= 16'h0000;
      stage_dots_q <= 4'h0;
      pending_q    <= 1'b0;
      disp_val_q   <= 16'h0000;
      disp_dots_q  <= 4'h0;
      frame_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      digit_q      <= digit_d;
      stage_val_q  <= stage_val_d;
      stage_dots_q <= stage_dots_d;
      pending_q    <= pending_d;
      disp_val_q   <= disp_val_d;
      disp_dots_q  <= disp_dots_d;
      frame_q      <= frame_d;
    end
  end

  // lz_blank[k]: digit k and every more-significant digit show nothing (no nibble, no dot).
  logic [3:0] lz_blank;
  assign lz_blank[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 4; gi++) begin : g_lz
      assign lz_blank[gi] = (disp_val_q[15:4*gi] == '0) && (disp_dots_q[3:gi] == '0);
    end
  endgenerate

  assign PENDING_OUT    = pending_q;
  assign SEG_SELECT_OUT = digit_q;
  assign BIN_OUT        = disp_val_q[{digit_q, 2'b00} +: 4];
  assign DOT_OUT        = disp_dots_q[digit_q];
  assign BLANK_OUT      = !ENABLE_IN || (BLANK_LZ_IN && lz_blank[digit_q]);
  assign FRAME_OUT      = frame_q && ENABLE_IN;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4: one digit per 4 cycles,
// one frame per 16 cycles, tracked by a cycle counter since the last reset.
module tb_seg_scan_driver;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE_IN;
  logic        LOAD_IN;
  logic [15:0] VALUE_IN;
  logic [3:0]  DOTS_IN;
  logic        BLANK_LZ_IN;
  logic        PENDING_OUT;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        BLANK_OUT;
  logic        FRAME_OUT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_scan_driver #(.REFRESH_DIV(4)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .ENABLE_IN      (ENABLE_IN),
    .LOAD_IN        (LOAD_IN),
    .VALUE_IN       (VALUE_IN),
    .DOTS_IN        (DOTS_IN),
    .BLANK_LZ_IN    (BLANK_LZ_IN),
    .PENDING_OUT    (PENDING_OUT),
    .SEG_SELECT_OUT (SEG_SELECT_OUT),
    .BIN_OUT        (BIN_OUT),
    .DOT_OUT        (DOT_OUT),
    .BLANK_OUT      (BLANK_OUT),
    .FRAME_OUT      (FRAME_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock while scanning: digit select and frame pulse follow from cyc alone.
  task automatic step();
    logic [15:0] exp_sel;
    logic [15:0] exp_frame;
    @(posedge CLK);
    #1;
    cyc++;
    exp_sel   = 16'((cyc / 4) % 4);
    exp_frame = (cyc % 16 == 0) ? 16'd1 : 16'd0;
    chk("sel", {14'd0, SEG_SELECT_OUT}, exp_sel);
    chk("frame", {15'd0, FRAME_OUT}, exp_frame);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    LOAD_IN  = 1'b1;
    VALUE_IN = v;
    DOTS_IN  = d;
    $display("cyc %0d: load value=%h dots=%b", cyc, v, d);
    step();
    LOAD_IN  = 1'b0;
  endtask

  task automatic chk_digit(input string tag, input logic [3:0] bin, input logic dot, input logic blank);
    chk({tag, "_bin"}, {12'd0, BIN_OUT}, {12'd0, bin});
    chk({tag, "_dot"}, {15'd0, DOT_OUT}, {15'd0, dot});
    chk({tag, "_blank"}, {15'd0, BLANK_OUT}, {15'd0, blank});
  endtask

  initial begin
    RESET       = 1'b0;
    ENABLE_IN   = 1'b1;
    LOAD_IN     = 1'b0;
    VALUE_IN    = 16'h0000;
    DOTS_IN     = 4'h0;
    BLANK_LZ_IN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_sel", {14'd0, SEG_SELECT_OUT}, 16'd0);
    chk("rst_pending", {15'd0, PENDING_OUT}, 16'd0);
    chk("rst_frame", {15'd0, FRAME_OUT}, 16'd0);
    chk_digit("rst", 4'h0, 1'b0, 1'b0);
    RESET = 1'b1;
    cyc   = 0;

    // Free-running scan with an empty display.
    run_to(20);
    chk("idle_bin", {12'd0, BIN_OUT}, 16'h0);

    // Load during digit 1; applied at the 3->0 transition at cyc 32.
    load(16'h12AF, 4'b0100);
    chk("pend_set", {15'd0, PENDING_OUT}, 16'd1);
    run_to(31);
    chk("pend_hold", {15'd0, PENDING_OUT}, 16'd1);
    chk("old_bin", {12'd0, BIN_OUT}, 16'h0);
    run_to(32);
    chk("pend_clr", {15'd0, PENDING_OUT}, 16'd0);
    chk_digit("d0", 4'hF, 1'b0, 1'b0);
    run_to(36); chk_digit("d1", 4'hA, 1'b0, 1'b0);
    run_to(40); chk_digit("d2", 4'h2, 1'b1, 1'b0);
    run_to(44); chk_digit("d3", 4'h1, 1'b0, 1'b0);

    // Two loads in one frame: latest wins.
    run_to(50); load(16'h1111, 4'h0);
    run_to(54); load(16'h2222, 4'h0);
    run_to(63); chk("prev_frame_bin", {12'd0, BIN_OUT}, 16'h1);
    for (int k = 0; k < 4; k++) begin
      run_to(64 + 4 * k);
      chk("latest_wins", {12'd0, BIN_OUT}, 16'h2);
    end

    // Load exactly on the boundary tick while 1111 is pending.
    run_to(84); load(16'h1111, 4'h0);
    run_to(95); load(16'h3333, 4'h0);
    chk("bnd_pending", {15'd0, PENDING_OUT}, 16'd1);
    chk("bnd_old_stage", {12'd0, BIN_OUT}, 16'h1);
    run_to(108); chk("bnd_frame_d3", {12'd0, BIN_OUT}, 16'h1);
    run_to(112);
    chk("bnd_next", {12'd0, BIN_OUT}, 16'h3);
    chk("bnd_pend_clr", {15'd0, PENDING_OUT}, 16'd0);

    // Leading-zero blanking.
    BLANK_LZ_IN = 1'b1;
    run_to(113); load(16'h0050, 4'h0);
    run_to(128); chk_digit("lz50_d0", 4'h0, 1'b0, 1'b0);
    run_to(132); chk_digit("lz50_d1", 4'h5, 1'b0, 1'b0);
    run_to(136); chk_digit("lz50_d2", 4'h0, 1'b0, 1'b1);
    run_to(140); chk_digit("lz50_d3", 4'h0, 1'b0, 1'b1);
    run_to(141); load(16'h0000, 4'h0);
    run_to(144); chk_digit("lz0_d0", 4'h0, 1'b0, 1'b0);
    run_to(148); chk_digit("lz0_d1", 4'h0, 1'b0, 1'b1);
    run_to(152); chk_digit("lz0_d2", 4'h0, 1'b0, 1'b1);
    run_to(156); chk_digit("lz0_d3", 4'h0, 1'b0, 1'b1);
    run_to(157); load(16'h0000, 4'b0100);
    run_to(164); chk_digit("lzdot_d1", 4'h0, 1'b0, 1'b0);
    run_to(168); chk_digit("lzdot_d2", 4'h0, 1'b1, 1'b0);
    run_to(172); chk_digit("lzdot_d3", 4'h0, 1'b0, 1'b1);

    // Freeze for 10 cycles in the middle of digit 2, loading while frozen.
    run_to(185);
    ENABLE_IN = 1'b0;
    LOAD_IN   = 1'b1;
    VALUE_IN  = 16'h0007;
    DOTS_IN   = 4'h0;
    $display("cyc %0d: load value=%h dots=%b (scan frozen)", cyc, VALUE_IN, DOTS_IN);
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK);
      #1;
      LOAD_IN = 1'b0;
      chk("frz_sel", {14'd0, SEG_SELECT_OUT}, 16'd2);
      chk("frz_blank", {15'd0, BLANK_OUT}, 16'd1);
      chk("frz_frame", {15'd0, FRAME_OUT}, 16'd0);
    end
    chk("frz_pending", {15'd0, PENDING_OUT}, 16'd1);
    ENABLE_IN = 1'b1;
    step();
    chk("resume_blank", {15'd0, BLANK_OUT}, 16'd0);
    run_to(191); chk("resume_pend", {15'd0, PENDING_OUT}, 16'd1);
    run_to(192);
    chk_digit("resume_d0", 4'h7, 1'b0, 1'b0);
    chk("resume_pend_clr", {15'd0, PENDING_OUT}, 16'd0);
    run_to(196); chk_digit("resume_d1", 4'h0, 1'b0, 1'b1);

    // Reset while a load is pending discards it.
    load(16'h9999, 4'hF);
    chk("pre_rst_pend", {15'd0, PENDING_OUT}, 16'd1);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid_rst_sel", {14'd0, SEG_SELECT_OUT}, 16'd0);
    chk("mid_rst_pend", {15'd0, PENDING_OUT}, 16'd0);
    chk("mid_rst_frame", {15'd0, FRAME_OUT}, 16'd0);
    chk_digit("mid_rst", 4'h0, 1'b0, 1'b0);
    RESET = 1'b1;
    cyc   = 0;
    run_to(16);
    chk_digit("post_rst", 4'h0, 1'b0, 1'b0);
    chk("post_rst_pend", {15'd0, PENDING_OUT}, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
